// File: rtl/stream_demux_pkg.sv
// Shared utility package: ceiling-log2 helper used to size select fields
// (also used by the companion stream mux), plus slot operation encoding.
package stream_demux_pkg;

    // Ceiling of log2(value); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Select width for a given port count, never narrower than one bit.
    function automatic int sel_width(input int ports);
        int w;
        w = clog2(ports);
        return (w < 1) ? 1 : w;
    endfunction

    // What a one-entry slot does on the next clock edge.
    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_FILL  = 2'd1,
        SLOT_DRAIN = 2'd2
    } slot_op_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: a valid flag plus a data register. A fill on the
// same edge as a drain wins, so a full slot can be refilled without a bubble.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fill,
    input  logic         drain,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    logic         valid_reg;
    logic [W-1:0] data_reg;
    slot_op_e     op;

    // Decide the slot operation; a drain only matters when the slot is full.
    always_comb begin
        op = SLOT_HOLD;
        if (fill) begin
            op = SLOT_FILL;
        end else if (drain && valid_reg) begin
            op = SLOT_DRAIN;
        end
    end

    // Slot state; data is left untouched on drain so the output holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            case (op)
                SLOT_FILL: begin
                    valid_reg <= 1'b1;
                    data_reg  <= din;
                end
                SLOT_DRAIN: begin
                    valid_reg <= 1'b0;
                end
                default: begin
                    valid_reg <= valid_reg;
                end
            endcase
        end
    end

    assign valid = valid_reg;
    assign dout  = data_reg;

endmodule

// File: rtl/stream_demux.sv
// Stream demultiplexer: routes each input beat to the output port named by
// in_sel. Each port owns an independent one-entry slot; out-of-range selects
// are swallowed and flagged on a sticky error bit.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int W    = 32,
    parameter  int N    = 2,
    localparam int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic [SELW-1:0] in_sel,
    output logic [N-1:0]    out_valid,
    input  logic [N-1:0]    out_ready,
    output logic [N*W-1:0]  out_data,
    output logic            sel_err
);

    logic [N-1:0] sel_hit;
    logic [N-1:0] port_ready;
    logic [N-1:0] fill;
    logic         sel_in_range;
    logic         accept;
    logic         bad_beat;
    logic         sel_err_reg;

    // Per-port decode, readiness and slot instances.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_port
            assign sel_hit[gi]    = (in_sel == SELW'(gi));
            assign port_ready[gi] = !out_valid[gi] || out_ready[gi];
            assign fill[gi]       = accept && sel_hit[gi];

            demux_slot #(
                .W(W)
            ) u_slot (
                .clk  (clk),
                .rst_n(rst_n),
                .fill (fill[gi]),
                .drain(out_ready[gi]),
                .din  (in_data),
                .valid(out_valid[gi]),
                .dout (out_data[gi*W +: W])
            );
        end
    endgenerate

    // Only indices below N can produce a hit, so no hit means an invalid select.
    assign sel_in_range = |sel_hit;

    // Input readiness: never during reset, always for a bad select (beat is
    // dropped), otherwise whether the addressed slot is free or draining now.
    always_comb begin
        in_ready = 1'b0;
        if (!rst_n) begin
            in_ready = 1'b0;
        end else if (sel_in_range) begin
            in_ready = |(sel_hit & port_ready);
        end else begin
            in_ready = 1'b1;
        end
    end

    assign accept   = in_valid && in_ready && sel_in_range;
    assign bad_beat = in_valid && in_ready && !sel_in_range;

    // Sticky select-error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_reg <= 1'b0;
        end else if (bad_beat) begin
            sel_err_reg <= 1'b1;
        end
    end

    assign sel_err = sel_err_reg;

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter W, default 32, data width of each beat in bits.
REQ-002 SHALL have parameter N, default 2, number of output ports (N >= 2).
REQ-003 SHALL have derived localparam SELW = max(1, ceil(log2(N))), select width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 in_valid  input  1  beat offered on input.
REQ-007 in_ready  output  1  input beat can be accepted this cycle.
REQ-008 in_data  input  W  beat payload.
REQ-009 in_sel  input  SELW  destination port index for the offered beat.
REQ-010 out_valid  output  N  bit i: port i holds a beat.
REQ-011 out_ready  input  N  bit i: consumer i takes the beat this cycle.
REQ-012 out_data  output  N*W  flattened; port i payload at bits [i*W +: W].
REQ-013 sel_err  output  1  sticky flag: a beat was offered with in_sel >= N.

Function
REQ-014 Each port SHALL own a one-entry slot (valid bit + W-bit data register).
REQ-015 Input transfer SHALL occur when in_valid && in_ready on a rising clk edge.
REQ-016 For in_sel < N, in_ready SHALL equal (!out_valid[in_sel] || out_ready[in_sel]), so a full slot drained in the same cycle can be refilled with no bubble.
REQ-017 For in_sel >= N, in_ready SHALL be 1, the beat SHALL be discarded, no slot SHALL change, and sel_err SHALL be set on that edge.
REQ-018 An accepted beat SHALL appear on port in_sel with out_valid high exactly one cycle after acceptance (latency 1), and SHALL NOT appear on any other port.
REQ-019 Output transfer on port i SHALL occur when out_valid[i] && out_ready[i]; the slot then empties unless refilled on the same edge.
REQ-020 Simultaneous drain and refill of slot i SHALL leave out_valid[i]=1 with the new data.
REQ-021 While out_valid[i]=1 and out_ready[i]=0, out_data slice i SHALL remain stable.
REQ-022 out_data slice i SHALL hold its last value when out_valid[i]=0 (not required to be zero).
REQ-023 in_ready SHALL depend combinationally only on in_sel, out_valid and out_ready; it SHALL NOT depend on in_valid.
REQ-024 Ports SHALL be independent: a stalled port SHALL NOT block beats to other ports.
REQ-025 Beats to one port SHALL be delivered in acceptance order; no ordering is guaranteed across ports.

Reset
REQ-026 On rst_n low, asynchronously: out_valid = 0 for all ports, sel_err = 0, all data registers = 0.
REQ-027 Beats held in slots at reset assertion SHALL be lost; no transfer SHALL complete while rst_n is low.
REQ-028 in_ready SHALL be 0 while rst_n is low.
REQ-029 First acceptance SHALL be possible on the first rising clk edge after rst_n deasserts.

Structure
REQ-030 A shared util package SHALL hold the clog2 function used for SELW, shared with the existing mux.
REQ-031 One sub-module demux_slot (W parameter; fill, drain, data in; valid, data out) SHALL be instantiated N times via generate.
REQ-032 Top-level SHALL contain only select decode, in_ready generation and sel_err logic.

Verification
REQ-033 Reset: hold rst_n=0, drive in_valid=1 -> out_valid=00, in_ready=0, sel_err=0; release -> in_ready=1.
REQ-034 Routing, N=2 W=32: in_data=5 sel=0, then in_data=1 sel=1, out_ready=11 -> out_data[31:0]=5 one cycle after first accept, out_data[63:32]=1 one cycle after second; other port's valid stays 0.
REQ-035 Backpressure: out_ready[0]=0, send 7 then 9 to port 0 -> 7 held stable, in_ready=0 for second beat; raise out_ready[0] -> 7 consumed and 9 accepted same edge, 9 visible next cycle.
REQ-036 Independence: port 0 stalled full, send 3 to port 1 -> accepted immediately, out_data[63:32]=3 next cycle.
REQ-037 Bad select, N=3 (SELW=2): in_sel=3, in_data=8 -> in_ready=1, no out_valid change, sel_err=1 and stays 1 until reset.
REQ-038 Reset mid-operation: both slots full, pulse rst_n low between edges -> out_valid=00 immediately, data registers 0, normal routing resumes after release.
